// File: rtl/load_store_unit.sv
// load_store_unit: serialises RISC-V loads/stores into single-byte memory transactions
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_func3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, data_q, data_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_k;
  logic              uns;
  logic [31:0]       ext;
  assign last_k = func3_q[1:0] == 2'b00 ? 2'd0 : func3_q[1:0] == 2'b01 ? 2'd1 : 2'd3;
  assign uns = func3_q[2] | (&func3_q[1:0]);
  assign ext = store_q ? '0 :
               func3_q[1:0] == 2'b00 ? {{24{~uns & data_q[7]}}, data_q[7:0]} :
               func3_q[1:0] == 2'b01 ? {{16{~uns & data_q[15]}}, data_q[15:0]} : data_q;
  assign req_ready_o  = state_q == IDLE;
  assign mem_req_o    = state_q == ACCESS;
  assign resp_valid_o = state_q == DONE;
  assign mem_we_o     = mem_req_o & store_q;
  assign mem_addr_o   = mem_req_o ? addr_q + ADDR_W'(k_q) : '0;
  assign mem_wdata_o  = mem_req_o ? wdata_q[{k_q, 3'b000} +: 8] : '0;
  assign resp_rdata_o = resp_valid_o ? ext : '0;
  // state and request registers; reset drops any transaction in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      k_q     <= k_d;
    end
  end
  // accept, step through bytes on ack, hold the response until taken
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        store_d = req_store_i;
        func3_d = req_func3_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        data_d  = '0;
        k_d     = '0;
        state_d = ACCESS;
      end
      ACCESS: if (mem_ack_i) begin
        if (!store_q) data_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
        k_d = k_q + 2'd1;
        if (k_q == last_k) state_d = DONE;
      end
      DONE: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-memory model and randomized traffic
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_func3_i(req_func3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bmem [256];
  logic [7:0] ref_mem [256];
  logic       load_mem = 1'b1;
  logic       rnd = 1'b0, rack = 1'b1, mack = 1'b1, rrdy = 1'b1, mrdy = 1'b1;

  assign mem_ack    = mem_req & (rnd ? rack : mack);
  assign resp_ready = rnd ? rrdy : mrdy;
  assign mem_rdata  = bmem[mem_addr];

  always @(posedge clk) begin
    if (load_mem) bmem <= ref_mem;
    else if (mem_req && mem_ack && mem_we) bmem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    #2;
    rack = $urandom_range(0, 3) != 0;
    rrdy = $urandom_range(0, 2) != 0;
  end

  typedef struct packed {logic we; logic [7:0] a; logic [7:0] d;} byte_t;
  byte_t       exp_b[$];
  logic [31:0] exp_r[$];
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: byte list and result straight from the access rules
  task automatic model(logic st, logic [2:0] f3, logic [7:0] a, logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] ai, di;
      ai = 8'((int'(a) + i) % 256);
      di = 8'(wd >> (8 * i));
      exp_b.push_back('{st, ai, di});
      if (st) ref_mem[ai] = di;
      else v = v | (32'(ref_mem[ai]) << (8 * i));
    end
    if (st) v = 0;
    else if (n == 1 && !f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    else if (n == 2 && !f3[2] && v[15]) v = v | 32'hFFFF_0000;
    exp_r.push_back(v);
  endtask

  logic       p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [7:0] p_a = '0, p_d = '0;

  always @(negedge clk) begin
    if (!mem_req) chk("mem_idle_zero", {23'd0, mem_we, mem_wdata}, 32'd0);
    if (!resp_valid) chk("rdata_idle_zero", resp_rdata, 32'd0);
    if (mem_req && p_req && !p_ack)
      chk("stall_stable", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, p_we, p_a, p_d});
    if (mem_req && mem_ack) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected: got addr %h with nothing expected", mem_addr);
      end else begin
        byte_t e;
        e = exp_b.pop_front();
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL byte_txn: got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                   mem_we, mem_addr, mem_wdata, e.we, e.a, e.d);
        end
      end
    end
    if (resp_valid && resp_ready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %h with nothing expected", resp_rdata);
      end else begin
        logic [31:0] e;
        e = exp_r.pop_front();
        if (resp_rdata !== e) begin
          errors++;
          $display("FAIL resp_data: got %h expected %h", resp_rdata, e);
        end
      end
    end
    p_req = mem_req;
    p_ack = mem_ack;
    p_we  = mem_we;
    p_a   = mem_addr;
    p_d   = mem_wdata;
  end

  task automatic issue(logic st, logic [2:0] f3, logic [7:0] a, logic [31:0] wd);
    int t;
    model(st, f3, a, wd);
    req_valid = 1'b1;
    req_store = st;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL req_timeout: req_ready stayed %b", req_ready);
    end
    @(posedge clk);
    #2;
    acc = cyc;
    req_valid = 1'b0;
    req_store = 1'($urandom);
    req_func3 = 3'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_resp(int lat, logic hold, output logic [31:0] rd);
    int t;
    rd = '0;
    t = 0;
    @(negedge clk);
    while (!resp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid stayed %b", resp_valid);
      return;
    end
    rd = resp_rdata;
    if (lat > 0) chk("latency", 32'(cyc - acc + 1), 32'(lat));
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold_rdata", resp_rdata, rd);
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #2;
      mrdy = 1'b1;
      @(negedge clk);
    end
    t = 0;
    while (!(resp_valid && resp_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(resp_valid && resp_ready)) begin
      errors++;
      $display("FAIL handshake_timeout: resp_valid %b resp_ready %b", resp_valid, resp_ready);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  lf3 [6];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h09; ref_mem[2] = 8'h19; ref_mem[3] = 8'h0F;
    ref_mem[5] = 8'h80; ref_mem[6] = 8'hFF;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem", {15'd0, mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    load_mem = 1'b0;
    rst_n = 1'b1;

    issue(1'b0, 3'b010, 8'h00, 32'h0);
    wait_resp(5, 1'b0, rd);
    chk("lw_0", rd, 32'h0F19_0911);
    issue(1'b0, 3'b000, 8'h05, 32'h0);
    wait_resp(2, 1'b0, rd);
    chk("lb_5", rd, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 8'h05, 32'h0);
    wait_resp(2, 1'b0, rd);
    chk("lbu_5", rd, 32'h0000_0080);
    issue(1'b0, 3'b001, 8'h05, 32'h0);
    wait_resp(3, 1'b0, rd);
    chk("lh_5", rd, 32'hFFFF_FF80);
    issue(1'b0, 3'b101, 8'h05, 32'h0);
    wait_resp(3, 1'b0, rd);
    chk("lhu_5", rd, 32'h0000_FF80);
    issue(1'b0, 3'b011, 8'h00, 32'h0);
    wait_resp(5, 1'b0, rd);
    chk("illegal_f3", rd, 32'h0F19_0911);

    issue(1'b0, 3'b001, 8'h05, 32'h0);
    @(posedge clk);
    #2;
    mack = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    mack = 1'b1;
    wait_resp(6, 1'b0, rd);
    chk("lh_stall", rd, 32'hFFFF_FF80);

    mrdy = 1'b0;
    issue(1'b0, 3'b000, 8'h06, 32'h0);
    wait_resp(2, 1'b1, rd);
    chk("lb_hold", rd, 32'hFFFF_FFFF);

    issue(1'b0, 3'b010, 8'h00, 32'h0);
    @(posedge clk);
    #2;
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_drop", {31'd0, mem_req}, 32'd0);
    exp_b.delete();
    exp_r.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_resp", {31'd0, resp_valid}, 32'd0);
    issue(1'b0, 3'b000, 8'h00, 32'h0);
    wait_resp(2, 1'b0, rd);
    chk("lb_after_rst", rd, 32'h0000_0011);

    issue(1'b1, 3'b010, 8'hFE, 32'hDEAD_BEEF);
    wait_resp(5, 1'b0, rd);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_fe", {24'd0, bmem[254]}, 32'hEF);
    chk("sw_ff", {24'd0, bmem[255]}, 32'hBE);
    chk("sw_00", {24'd0, bmem[0]}, 32'hAD);
    chk("sw_01", {24'd0, bmem[1]}, 32'hDE);

    rnd = 1'b1;
    repeat (200) begin
      logic st;
      st = 1'($urandom);
      issue(st, st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 5)], 8'($urandom), $urandom);
      wait_resp(0, 1'b0, rd);
    end
    rnd = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("queues_empty", 32'(exp_b.size() + exp_r.size()), 32'd0);
    for (int i = 0; i < 256; i++) chk("mem_image", {24'd0, bmem[i]}, {24'd0, ref_mem[i]});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
